// File: rtl/ap_cmd_tracker_pkg.sv
// rtl/ap_cmd_tracker_pkg.sv - shared DDR backend types and bank-index helpers
package ap_cmd_tracker_pkg;

    localparam int DEF_TOTALBANKS = 16;

    function automatic int bgbk_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    localparam int BGBK_W = bgbk_width(DEF_TOTALBANKS);

    typedef struct packed {
        logic              ap;
        logic              write;
        logic [BGBK_W-1:0] bgbk;
    } ap_entry_t;

endpackage

// File: rtl/ap_cmd_tracker_cmd_fifo.sv
// rtl/ap_cmd_tracker_cmd_fifo.sv - generic DEPTH x WIDTH circular FIFO with occupancy count
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ap_cmd_tracker.sv
// rtl/ap_cmd_tracker.sv - CAS tracker producing auto-precharge reservation and ack strobes
module ap_cmd_tracker
    import ap_cmd_tracker_pkg::*;
#(
    parameter int NUMBANK      = 4,
    parameter int NUMBANKGROUP = 4,
    parameter int TOTALBANKS   = NUMBANK * NUMBANKGROUP,
    parameter int DEPTH        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmdValid,
    output logic                          cmdReady,
    input  logic                          cmdWrite,
    input  logic                          cmdAP,
    input  logic [$clog2(TOTALBANKS)-1:0] cmdBGBK,
    input  logic [TOTALBANKS-1:0]         bankState,
    input  logic                          phyAck,
    output logic                          apSetup,
    output logic                          apMode,
    output logic [$clog2(TOTALBANKS)-1:0] apSetupBGBK,
    output logic                          apAck,
    output logic [$clog2(TOTALBANKS)-1:0] apAckBGBK,
    output logic [$clog2(DEPTH+1)-1:0]    outstanding,
    output logic                          ackError
);

    localparam int BW = bgbk_width(TOTALBANKS);

    // The write flag is consumed at accept time (apMode), so the queue keeps {ap, bgbk}
    logic [BW:0] push_entry;
    logic [BW:0] head;
    logic        full;
    logic        empty;
    logic        accept;
    logic        pop;

    assign push_entry = {cmdAP, cmdBGBK};
    assign accept     = cmdValid && cmdReady;
    assign pop        = phyAck && !empty;

    // Same-bank check against apSetup covers the cycle before bankState sees the reservation
    assign cmdReady = rst && !full && !bankState[cmdBGBK]
                      && !(apSetup && (apSetupBGBK == cmdBGBK));

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BW + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (outstanding)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            apSetup     <= 1'b0;
            apMode      <= 1'b0;
            apSetupBGBK <= '0;
            apAck       <= 1'b0;
            apAckBGBK   <= '0;
            ackError    <= 1'b0;
        end else begin
            apSetup <= accept && cmdAP;
            if (accept && cmdAP) begin
                apMode      <= cmdWrite;
                apSetupBGBK <= cmdBGBK;
            end
            apAck <= pop && head[BW];
            if (pop && head[BW]) apAckBGBK <= head[BW-1:0];
            if (phyAck && empty) ackError <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ap_cmd_tracker.sv
// tb/tb_ap_cmd_tracker.sv - directed scoreboard bench for ap_cmd_tracker
module tb_ap_cmd_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmdValid, cmdReady, cmdWrite, cmdAP;
    logic [3:0]  cmdBGBK;
    logic [15:0] bankState;
    logic        phyAck;
    logic        apSetup, apMode, apAck, ackError;
    logic [3:0]  apSetupBGBK, apAckBGBK;
    logic [3:0]  outstanding;

    typedef struct packed {
        logic       ap;
        logic [3:0] bk;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         m_cnt;
    logic       m_aps, m_mode, m_ack, m_err;
    logic [3:0] m_apsbk, m_ackbk;

    always #5 clk = ~clk;

    ap_cmd_tracker dut (
        .clk         (clk),
        .rst         (rst),
        .cmdValid    (cmdValid),
        .cmdReady    (cmdReady),
        .cmdWrite    (cmdWrite),
        .cmdAP       (cmdAP),
        .cmdBGBK     (cmdBGBK),
        .bankState   (bankState),
        .phyAck      (phyAck),
        .apSetup     (apSetup),
        .apMode      (apMode),
        .apSetupBGBK (apSetupBGBK),
        .apAck       (apAck),
        .apAckBGBK   (apAckBGBK),
        .outstanding (outstanding),
        .ackError    (ackError)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt = 0; m_aps = 0; m_mode = 0; m_ack = 0; m_err = 0;
        m_apsbk = 0; m_ackbk = 0;
    endtask

    task automatic cyc(input logic v, input logic w, input logic a, input logic [3:0] bk, input logic ack);
        logic er, acc, pop;
        exp_t h;
        cmdValid = v; cmdWrite = w; cmdAP = a; cmdBGBK = bk; phyAck = ack;
        #1;
        er = (m_cnt < 8) && !bankState[bk] && !(m_aps && (m_apsbk == bk));
        if (v) chk("cmdReady", cmdReady, er);
        acc = v && er;
        pop = ack && (m_cnt > 0);
        m_ack = 1'b0;
        if (pop) begin
            h = sb.pop_front();
            m_ack = h.ap;
            if (h.ap) m_ackbk = h.bk;
        end
        if (acc) sb.push_back('{ap: a, bk: bk});
        if (ack && m_cnt == 0) m_err = 1'b1;
        m_cnt = m_cnt + int'(acc) - int'(pop);
        m_aps = acc && a;
        if (m_aps) begin
            m_mode  = w;
            m_apsbk = bk;
        end
        @(posedge clk);
        #1;
        cmdValid = 1'b0; phyAck = 1'b0;
        chk("apSetup", apSetup, m_aps);
        chk("apMode", apMode, m_mode);
        if (m_aps) chk("apSetupBGBK", apSetupBGBK, m_apsbk);
        chk("apAck", apAck, m_ack);
        if (m_ack) chk("apAckBGBK", apAckBGBK, m_ackbk);
        chk("outstanding", outstanding, m_cnt);
        chk("ackError", ackError, m_err);
    endtask

    initial begin
        rst = 1'b0; cmdValid = 1'b1; cmdWrite = 1'b0; cmdAP = 1'b1; cmdBGBK = 4'd5;
        bankState = '0; phyAck = 1'b0;
        model_reset();
        #2;
        chk("rst_cmdReady", cmdReady, 0);
        chk("rst_apSetup", apSetup, 0);
        chk("rst_apAck", apAck, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_ackError", ackError, 0);
        @(posedge clk); #1;
        rst = 1'b1; cmdValid = 1'b0;

        // READ-AP to bank 5, acked on the following cycle
        repeat (7) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 1, 4'd5, 0);
        chk("t1_apSetup", apSetup, 1);
        chk("t1_apMode", apMode, 0);
        chk("t1_apSetupBGBK", apSetupBGBK, 5);
        cyc(0, 0, 0, 0, 1);
        chk("t1_apSetup_once", apSetup, 0);
        chk("t1_apAck", apAck, 1);
        chk("t1_apAckBGBK", apAckBGBK, 5);
        chk("t1_outstanding", outstanding, 0);
        cyc(0, 0, 0, 0, 0);

        // WRITE-AP bank 3, then bank 3 blocked by hazard and by bankState
        cyc(1, 1, 1, 4'd3, 0);
        chk("t2_apMode", apMode, 1);
        cyc(1, 0, 0, 4'd3, 0);
        bankState[3] = 1'b1;
        repeat (3) cyc(1, 0, 0, 4'd3, 0);
        bankState[3] = 1'b0;
        cyc(1, 0, 0, 4'd3, 0);
        chk("t2_outstanding", outstanding, 2);
        cyc(0, 0, 0, 0, 1);
        chk("t2_apAckBGBK", apAckBGBK, 3);
        cyc(0, 0, 0, 0, 1);

        // fill to full with non-AP commands
        for (int i = 0; i < 8; i++) cyc(1, i[0], 0, 4'(i), 0);
        chk("t3_full", outstanding, 8);
        cmdValid = 1'b1; cmdBGBK = 4'd12; #1;
        chk("t3_ready_full", cmdReady, 0);
        cyc(1, 0, 0, 4'd8, 1);
        chk("t3_pop_no_push", outstanding, 7);
        cyc(1, 0, 0, 4'd9, 0);
        chk("t3_refill", outstanding, 8);
        repeat (8) cyc(0, 0, 0, 0, 1);

        // interleaved AP / non-AP ordering
        cyc(1, 0, 1, 4'd1, 0);
        cyc(1, 0, 0, 4'd2, 0);
        cyc(1, 1, 1, 4'd9, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t4_ack1", {apAck, apAckBGBK}, {1'b1, 4'd1});
        cyc(0, 0, 0, 0, 1);
        chk("t4_ack2", apAck, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t4_ack3", {apAck, apAckBGBK}, {1'b1, 4'd9});

        // pointer wrap with simultaneous push/pop
        cyc(1, 0, 1, 4'd0, 0);
        cyc(1, 0, 0, 4'd1, 0);
        for (int i = 0; i < 20; i++) cyc(1, i[0], (i % 3) == 0, 4'((i + 2) % 16), 1);
        chk("t5_outstanding", outstanding, 2);
        repeat (2) cyc(0, 0, 0, 0, 1);

        // ack on empty queue, then reset mid-traffic
        cyc(0, 0, 0, 0, 1);
        chk("t6_ackError", ackError, 1);
        chk("t6_apAck", apAck, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_ackError_sticky", ackError, 1);
        cyc(1, 0, 1, 4'd4, 0);
        cyc(1, 1, 1, 4'd6, 0);
        rst = 1'b0; cmdValid = 1'b1; cmdBGBK = 4'd7;
        #2;
        chk("t6_rst_apSetup", apSetup, 0);
        chk("t6_rst_apMode", apMode, 0);
        chk("t6_rst_apSetupBGBK", apSetupBGBK, 0);
        chk("t6_rst_outstanding", outstanding, 0);
        chk("t6_rst_ackError", ackError, 0);
        chk("t6_rst_cmdReady", cmdReady, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1; cmdValid = 1'b0;
        cyc(1, 0, 1, 4'd2, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t6_post_apAckBGBK", apAckBGBK, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
